store_request_unit: RTL and testbench

//  Store-side counterpart of write-back load extraction. Sits in the MEM stage.

---
 rtl/store_request_unit.sv | 198 +++++++++++++++++++
 tb/tb_store_request_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_request_unit.sv
// MEM-stage store unit: turns SB/SH/SW/SWL/SWR/SC into an aligned bus write request,
// runs the req/addr_ok/data_ok handshake and holds the pipeline until the write completes.
module store_request_unit #(
  parameter bit ISSUE_COMB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  aluop,
  input  logic [31:0] m_vaddr,
  input  logic [31:0] st_data,
  input  logic        llbit,
  input  logic        flush,
  input  logic        mem_adv,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        ades,
  output logic        sc_result,
  output logic        stallreq
);

  // Store opcodes as encoded in the pipeline's ALUOp field.
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SWL = 8'h2a;
  localparam logic [7:0] OP_SW  = 8'h2b;
  localparam logic [7:0] OP_SWR = 8'h2e;
  localparam logic [7:0] OP_SC  = 8'h38;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]  a;
  logic        is_store;
  logic        is_sc;
  logic        misaligned;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;
  logic        go;
  logic        issue;
  logic        use_comb;
  logic        complete_now;
  logic        latch_en;
  logic        aborted_q;
  logic        aborted_nxt;
  logic        sc_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;

  assign a = m_vaddr[1:0];

  always_comb begin
    is_store   = 1'b0;
    misaligned = 1'b0;
    strb_c     = 4'b0000;
    wdata_c    = 32'h0;
    case (aluop)
      OP_SB: begin
        is_store = 1'b1;
        strb_c   = 4'b0001 << a;
        wdata_c  = {4{st_data[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = a[0];
        strb_c     = a[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{st_data[15:0]}};
      end
      OP_SW, OP_SC: begin
        is_store   = 1'b1;
        misaligned = (a != 2'b00);
        strb_c     = 4'b1111;
        wdata_c    = st_data;
      end
      OP_SWL: begin
        is_store = 1'b1;
        case (a)
          2'd0:    begin strb_c = 4'b0001; wdata_c = {24'h0, st_data[31:24]}; end
          2'd1:    begin strb_c = 4'b0011; wdata_c = {16'h0, st_data[31:16]}; end
          2'd2:    begin strb_c = 4'b0111; wdata_c = {8'h0, st_data[31:8]};   end
          default: begin strb_c = 4'b1111; wdata_c = st_data;                 end
        endcase
      end
      OP_SWR: begin
        is_store = 1'b1;
        case (a)
          2'd0:    begin strb_c = 4'b1111; wdata_c = st_data;                 end
          2'd1:    begin strb_c = 4'b1110; wdata_c = {st_data[23:0], 8'h0};  end
          2'd2:    begin strb_c = 4'b1100; wdata_c = {st_data[15:0], 16'h0}; end
          default: begin strb_c = 4'b1000; wdata_c = {st_data[7:0], 24'h0};  end
        endcase
      end
      default: ;
    endcase
  end

  assign is_sc = (aluop == OP_SC);
  assign ades  = en & is_store & misaligned;
  assign go    = en & is_store & ~misaligned & ~flush & ~(is_sc & ~llbit);
  // Reset must silence the request and stall at once, even with en still high.
  assign issue = go & ~rst;

  // aborted_q marks an accepted write whose instruction was flushed: finish the bus cycle, never report DONE.
  always_comb begin
    state_nxt    = state;
    m_req        = 1'b0;
    complete_now = 1'b0;
    stallreq     = 1'b0;
    latch_en     = 1'b0;
    aborted_nxt  = aborted_q;
    case (state)
      S_IDLE: begin
        aborted_nxt = 1'b0;
        m_req       = ISSUE_COMB & issue;
        stallreq    = issue;
        if (issue) begin
          latch_en = 1'b1;
          if (ISSUE_COMB && m_addr_ok) begin
            state_nxt = m_data_ok ? S_DONE : S_RESP;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        m_req        = 1'b1;
        complete_now = m_addr_ok & m_data_ok;
        stallreq     = issue & ~complete_now;
        if (m_addr_ok) begin
          if (m_data_ok) begin
            state_nxt = (flush || mem_adv) ? S_IDLE : S_DONE;
          end else begin
            state_nxt   = S_RESP;
            aborted_nxt = flush;
          end
        end else if (flush) begin
          state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        complete_now = m_data_ok;
        stallreq     = ~m_data_ok & ~rst;
        if (flush) begin
          aborted_nxt = 1'b1;
        end
        if (m_data_ok) begin
          state_nxt = (aborted_q || flush || mem_adv) ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (flush || mem_adv) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign sc_result = sc_q & ((state == S_DONE) | (complete_now & ~aborted_q & ~flush));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      aborted_q <= 1'b0;
      sc_q      <= 1'b0;
      addr_q    <= 32'h0;
      strb_q    <= 4'b0000;
      wdata_q   <= 32'h0;
    end else begin
      state     <= state_nxt;
      aborted_q <= aborted_nxt;
      if (latch_en) begin
        sc_q    <= is_sc;
        addr_q  <= {m_vaddr[31:2], 2'b00};
        strb_q  <= strb_c;
        wdata_q <= wdata_c;
      end
    end
  end

  // In the combinational-issue cycle the bus sees the live values; afterwards the latched copy.
  assign use_comb = ISSUE_COMB && (state == S_IDLE) && issue;
  assign m_addr   = use_comb ? {m_vaddr[31:2], 2'b00} : addr_q;
  assign m_wstrb  = use_comb ? strb_c : strb_q;
  assign m_wdata  = use_comb ? wdata_c : wdata_q;

endmodule

// File: tb/tb_store_request_unit.sv
// Randomised and directed bench for store_request_unit against a byte-lane reference model.
module tb_store_request_unit;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SWL = 8'h2a;
  localparam logic [7:0] OP_SW  = 8'h2b;
  localparam logic [7:0] OP_SWR = 8'h2e;
  localparam logic [7:0] OP_SC  = 8'h38;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  aluop;
  logic [31:0] m_vaddr;
  logic [31:0] st_data;
  logic        llbit;
  logic        flush;
  logic        mem_adv;
  logic        m_req;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic        ades;
  logic        sc_result;
  logic        stallreq;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  store_request_unit #(.ISSUE_COMB(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .aluop(aluop), .m_vaddr(m_vaddr), .st_data(st_data),
    .llbit(llbit), .flush(flush), .mem_adv(mem_adv), .m_req(m_req), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .ades(ades), .sc_result(sc_result), .stallreq(stallreq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic modelIsStore(input logic [7:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SWL || op == OP_SWR || op == OP_SC;
  endfunction

  function automatic logic modelAdes(input logic [7:0] op, input int a);
    return (op == OP_SH && (a % 2) == 1) || ((op == OP_SW || op == OP_SC) && a != 0);
  endfunction

  // Lanes written: SWL covers lanes 0..a, SWR covers lanes a..3.
  function automatic logic [3:0] modelStrb(input logic [7:0] op, input int a);
    int s;
    s = 0;
    if (op == OP_SB)       s = 1 << a;
    else if (op == OP_SH)  s = 3 << a;
    else if (op == OP_SWL) s = (1 << (a + 1)) - 1;
    else if (op == OP_SWR) s = (15 << a) & 15;
    else                   s = 15;
    return 4'(s);
  endfunction

  function automatic logic [31:0] modelData(input logic [7:0] op, input logic [31:0] rt, input int a);
    logic [31:0] b, h;
    b = rt & 32'hff;
    h = rt & 32'hffff;
    if (op == OP_SB)       return b * 32'h0101_0101;
    else if (op == OP_SH)  return h * 32'h0001_0001;
    else if (op == OP_SWL) return rt >> (8 * (3 - a));
    else if (op == OP_SWR) return rt << (8 * a);
    else                   return rt;
  endfunction

  // Entered and left at one time unit after a rising edge; outputs sampled 3 units later.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] va, input logic [31:0] rt,
                               input logic ll, input int addrDelay, input int dataDelay, input int holdCycles);
    int a;
    logic isSc, expAdes, expGo, finished;
    int doneCyc;
    a        = int'(va[1:0]);
    isSc     = (op == OP_SC);
    expAdes  = modelIsStore(op) && modelAdes(op, a);
    expGo    = modelIsStore(op) && !expAdes && !(isSc && !ll);
    doneCyc  = addrDelay + dataDelay;
    finished = 1'b0;
    en = 1'b1; aluop = op; m_vaddr = va; st_data = rt; llbit = ll;
    if (!expGo) begin
      for (int i = 0; i < 2; i++) begin
        #3;
        checkOutput("noacc_ades", ades, expAdes);
        checkOutput("noacc_req", m_req, 0);
        checkOutput("noacc_stall", stallreq, 0);
        checkOutput("noacc_sc", sc_result, 0);
        @(posedge clk); #1;
      end
    end else begin
      for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
        #1;
        m_addr_ok = m_req && (cyc == addrDelay);
        m_data_ok = (cyc == doneCyc);
        mem_adv   = (cyc == doneCyc) && (holdCycles == 0);
        #2;
        checkOutput("req", m_req, cyc <= addrDelay);
        checkOutput("stall", stallreq, cyc < doneCyc);
        checkOutput("ades_ok", ades, 0);
        if (cyc == 0 || cyc == addrDelay) begin
          checkOutput("addr", m_addr, {va[31:2], 2'b00});
          checkOutput("strb", m_wstrb, modelStrb(op, a));
          checkOutput("wdata", m_wdata, modelData(op, rt, a));
        end
        if (cyc == doneCyc) begin
          checkOutput("sc_complete", sc_result, isSc);
          finished = 1'b1;
        end
        @(posedge clk); #1;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; mem_adv = 1'b0;
      end
      if (!finished) checkOutput("timeout", 0, 1);
      for (int h = 0; h < holdCycles; h++) begin
        #1;
        mem_adv = (h == holdCycles - 1);
        #2;
        checkOutput("hold_req", m_req, 0);
        checkOutput("hold_stall", stallreq, 0);
        checkOutput("hold_sc", sc_result, isSc);
        @(posedge clk); #1;
        mem_adv = 1'b0;
      end
    end
    en = 1'b0; aluop = OP_NOP;
    #3;
    checkOutput("gap_req", m_req, 0);
    checkOutput("gap_sc", sc_result, 0);
    @(posedge clk); #1;
  endtask

  logic [7:0] ops [7] = '{OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_SC, OP_NOP};

  initial begin
    rst = 1'b1; en = 1'b0; aluop = OP_NOP; m_vaddr = 32'h0; st_data = 32'h0; llbit = 1'b0;
    flush = 1'b0; mem_adv = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req", m_req, 0);
    checkOutput("rst_addr", m_addr, 0);
    checkOutput("rst_strb", m_wstrb, 0);
    checkOutput("rst_wdata", m_wdata, 0);
    checkOutput("rst_sc", sc_result, 0);
    checkOutput("rst_stall", stallreq, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(OP_SB, 32'h1000_0003, 32'h1234_56AB, 1'b0, 2, 1, 0);
    applyStimulus(OP_SH, 32'h1000_0001, 32'h1234_5678, 1'b0, 1, 0, 0);
    applyStimulus(OP_SW, 32'h1000_0002, 32'h1234_5678, 1'b0, 1, 0, 0);
    applyStimulus(OP_SH, 32'h1000_0000, 32'h1234_5678, 1'b0, 1, 1, 0);
    applyStimulus(OP_SH, 32'h1000_0002, 32'h1234_5678, 1'b0, 2, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(OP_SWL, 32'h2000_0000 + i, 32'hAABB_CCDD, 1'b0, 1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(OP_SWR, 32'h2000_0000 + i, 32'hAABB_CCDD, 1'b0, 1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(OP_SB, 32'h2000_0040 + i, 32'h0000_00C3, 1'b0, 1, 0, 0);
    applyStimulus(OP_SC, 32'h1000_0010, 32'hCAFE_F00D, 1'b0, 1, 0, 0);
    applyStimulus(OP_SC, 32'h1000_0010, 32'hCAFE_F00D, 1'b1, 1, 1, 5);
    applyStimulus(OP_SW, 32'h1000_0020, 32'h0BAD_F00D, 1'b0, 1, 0, 0);

    // Flush while the request is still unaccepted: withdrawn next cycle.
    en = 1'b1; aluop = OP_SW; m_vaddr = 32'h3000_0010; st_data = 32'hDEAD_BEEF; llbit = 1'b0;
    #3 checkOutput("flreq_c0_req", m_req, 1);
    @(posedge clk); #1 flush = 1'b1;
    #3 checkOutput("flreq_c1_req", m_req, 1);
    checkOutput("flreq_c1_stall", stallreq, 0);
    @(posedge clk); #1 flush = 1'b0; en = 1'b0; aluop = OP_NOP;
    #3 checkOutput("flreq_c2_req", m_req, 0);
    checkOutput("flreq_c2_stall", stallreq, 0);
    @(posedge clk); #1;

    // Flush after acceptance: stall until data_ok, then straight back to idle.
    en = 1'b1; aluop = OP_SC; m_vaddr = 32'h3000_0020; st_data = 32'h1357_9BDF; llbit = 1'b1;
    #3 checkOutput("flresp_c0_req", m_req, 1);
    @(posedge clk); #1 m_addr_ok = 1'b1;
    #3 checkOutput("flresp_c1_req", m_req, 1);
    @(posedge clk); #1 m_addr_ok = 1'b0; flush = 1'b1;
    #3 checkOutput("flresp_c2_stall", stallreq, 1);
    checkOutput("flresp_c2_req", m_req, 0);
    @(posedge clk); #1 flush = 1'b0; en = 1'b0; aluop = OP_NOP; llbit = 1'b0;
    #3 checkOutput("flresp_c3_stall", stallreq, 1);
    @(posedge clk); #1 m_data_ok = 1'b1;
    #3 checkOutput("flresp_c4_stall", stallreq, 0);
    checkOutput("flresp_c4_sc", sc_result, 0);
    @(posedge clk); #1 m_data_ok = 1'b0;
    applyStimulus(OP_SW, 32'h3000_0030, 32'h2468_ACE0, 1'b0, 1, 0, 0);

    // Reset while waiting for data_ok.
    en = 1'b1; aluop = OP_SC; m_vaddr = 32'h4000_0008; st_data = 32'h5555_AAAA; llbit = 1'b1;
    @(posedge clk); #1 m_addr_ok = 1'b1;
    @(posedge clk); #1 m_addr_ok = 1'b0;
    #1 checkOutput("rresp_pre_stall", stallreq, 1);
    rst = 1'b1;
    #1;
    checkOutput("rresp_req", m_req, 0);
    checkOutput("rresp_addr", m_addr, 0);
    checkOutput("rresp_strb", m_wstrb, 0);
    checkOutput("rresp_wdata", m_wdata, 0);
    checkOutput("rresp_sc", sc_result, 0);
    checkOutput("rresp_stall", stallreq, 0);
    @(posedge clk); #1 en = 1'b0; aluop = OP_NOP; llbit = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      applyStimulus(ops[$urandom_range(0, 6)], $urandom, $urandom, 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
